// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller: Moore control FSM and ALU/immediate decode for the
// multi-cycle RV32I core.  Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_imm_src,
  output logic [3:0] o_alu_control,
  output logic       o_illegal,
  output logic       o_retire
);

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_RALU = 7'b0110011;
  localparam logic [6:0] c_OP_IALU = 7'b0010011;
  localparam logic [6:0] c_OP_BTYP = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;

  localparam logic [1:0] c_RES_ALU  = 2'b00;
  localparam logic [1:0] c_RES_MEM  = 2'b01;
  localparam logic [1:0] c_RES_PC4  = 2'b10;
  localparam logic [1:0] c_A_PC     = 2'b00;
  localparam logic [1:0] c_A_OLDPC  = 2'b01;
  localparam logic [1:0] c_A_RD1    = 2'b10;
  localparam logic [1:0] c_B_RD2    = 2'b00;
  localparam logic [1:0] c_B_IMM    = 2'b01;
  localparam logic [1:0] c_B_FOUR   = 2'b10;

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b1000;
  localparam logic [3:0] c_ALU_SLT  = 4'b0010;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_OR   = 4'b0110;
  localparam logic [3:0] c_ALU_AND  = 4'b0111;

  localparam logic [3:0] c_S_FETCH    = 4'd0;
  localparam logic [3:0] c_S_DECODE   = 4'd1;
  localparam logic [3:0] c_S_MEMADR   = 4'd2;
  localparam logic [3:0] c_S_MEMREAD  = 4'd3;
  localparam logic [3:0] c_S_MEMWB    = 4'd4;
  localparam logic [3:0] c_S_MEMWRITE = 4'd5;
  localparam logic [3:0] c_S_EXECUTER = 4'd6;
  localparam logic [3:0] c_S_EXECUTEI = 4'd7;
  localparam logic [3:0] c_S_ALUWB    = 4'd8;
  localparam logic [3:0] c_S_BEQ      = 4'd9;
  localparam logic [3:0] c_S_JAL      = 4'd10;
  localparam logic [3:0] c_S_ILLEGAL  = 4'd11;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_pc_update;
  logic       w_branch;
  logic [1:0] w_alu_op;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_retire;
  logic       w_illegal;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= c_S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = c_S_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = c_RES_ALU;
    w_alu_src_a  = c_A_PC;
    w_alu_src_b  = c_B_RD2;
    case (r_state)
      c_S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_a  = c_A_PC;
        w_alu_src_b  = c_B_FOUR;
        w_result_src = c_RES_PC4;
        w_pc_update  = 1'b1;
        w_next_state = c_S_DECODE;
      end
      c_S_DECODE: begin
        // Branch target precomputed here while the register file is read.
        w_alu_src_a = c_A_OLDPC;
        w_alu_src_b = c_B_IMM;
        case (i_op)
          c_OP_LW, c_OP_SW: w_next_state = c_S_MEMADR;
          c_OP_RALU:        w_next_state = c_S_EXECUTER;
          c_OP_IALU:        w_next_state = c_S_EXECUTEI;
          c_OP_BTYP:        w_next_state = c_S_BEQ;
          c_OP_JAL:         w_next_state = c_S_JAL;
          default:          w_next_state = c_S_ILLEGAL;
        endcase
      end
      c_S_MEMADR: begin
        w_alu_src_a  = c_A_RD1;
        w_alu_src_b  = c_B_IMM;
        w_next_state = (i_op == c_OP_LW) ? c_S_MEMREAD : c_S_MEMWRITE;
      end
      c_S_MEMREAD: begin
        w_adr_src    = 1'b1;
        w_result_src = c_RES_ALU;
        w_next_state = c_S_MEMWB;
      end
      c_S_MEMWB: begin
        w_result_src = c_RES_MEM;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = c_S_FETCH;
      end
      c_S_MEMWRITE: begin
        w_adr_src    = 1'b1;
        w_result_src = c_RES_ALU;
        w_mem_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = c_S_FETCH;
      end
      c_S_EXECUTER: begin
        w_alu_src_a  = c_A_RD1;
        w_alu_src_b  = c_B_RD2;
        w_alu_op     = 2'b10;
        w_next_state = c_S_ALUWB;
      end
      c_S_EXECUTEI: begin
        w_alu_src_a  = c_A_RD1;
        w_alu_src_b  = c_B_IMM;
        w_alu_op     = 2'b10;
        w_next_state = c_S_ALUWB;
      end
      c_S_ALUWB: begin
        w_result_src = c_RES_ALU;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = c_S_FETCH;
      end
      c_S_BEQ: begin
        w_alu_src_a  = c_A_RD1;
        w_alu_src_b  = c_B_RD2;
        w_alu_op     = 2'b01;
        w_result_src = c_RES_ALU;
        w_branch     = 1'b1;
        w_retire     = 1'b1;
        w_next_state = c_S_FETCH;
      end
      c_S_JAL: begin
        w_alu_src_a  = c_A_OLDPC;
        w_alu_src_b  = c_B_FOUR;
        w_result_src = c_RES_ALU;
        w_pc_update  = 1'b1;
        w_next_state = c_S_ALUWB;
      end
      c_S_ILLEGAL: begin
        w_illegal    = 1'b1;
        w_next_state = c_S_ILLEGAL;
      end
      default: w_next_state = c_S_FETCH;
    endcase
  end

  // Enables are gated by reset so nothing is written while it is held.
  assign o_pc_write   = ~i_arst & (w_pc_update | (w_branch & i_zero));
  assign o_mem_write  = ~i_arst & w_mem_write;
  assign o_ir_write   = ~i_arst & w_ir_write;
  assign o_reg_write  = ~i_arst & w_reg_write;
  assign o_retire     = ~i_arst & w_retire;
  assign o_illegal    = ~i_arst & w_illegal;
  assign o_adr_src    = w_adr_src;
  assign o_result_src = w_result_src;
  assign o_alu_src_a  = w_alu_src_a;
  assign o_alu_src_b  = w_alu_src_b;

  always_comb begin
    o_imm_src = 2'b00;
    case (i_op)
      c_OP_SW:   o_imm_src = 2'b01;
      c_OP_BTYP: o_imm_src = 2'b10;
      c_OP_JAL:  o_imm_src = 2'b11;
      default:   o_imm_src = 2'b00;
    endcase
  end

  always_comb begin
    o_alu_control = c_ALU_ADD;
    case (w_alu_op)
      2'b01: o_alu_control = c_ALU_SUB;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_alu_control = ((i_op == c_OP_RALU) && i_funct7b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b010:  o_alu_control = c_ALU_SLT;
          3'b100:  o_alu_control = c_ALU_XOR;
          3'b110:  o_alu_control = c_ALU_OR;
          3'b111:  o_alu_control = c_ALU_AND;
          default: o_alu_control = c_ALU_ADD;
        endcase
      end
      default: o_alu_control = c_ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller: randomized self-checking bench for the multi-cycle
// control FSM against a per-instruction cycle model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BT = 7'b1100011, JL = 7'b1101111;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLT = 4'b0010;
  localparam logic [3:0] XOR = 4'b0100, OR_ = 4'b0110, AND_ = 4'b0111;

  logic       clk = 1'b0;
  logic       arst;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write;
  logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src;
  logic [3:0] o_alu_control;
  logic       o_illegal, o_retire;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .i_clk(clk), .i_arst(arst), .i_op(i_op), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero),
    .o_pc_write(o_pc_write), .o_adr_src(o_adr_src), .o_mem_write(o_mem_write),
    .o_ir_write(o_ir_write), .o_reg_write(o_reg_write), .o_result_src(o_result_src),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_imm_src(o_imm_src),
    .o_alu_control(o_alu_control), .o_illegal(o_illegal), .o_retire(o_retire)
  );

  always #5 clk = ~clk;

  // Expected outputs for cycle 'step' of an instruction counted from FETCH.
  function automatic logic [18:0] model(input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7, input logic z, input int step);
    logic pcw, adr, memw, irw, regw, ill, ret;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] alu;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; ill = 0; ret = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = ADD;
    imm = (op == SW) ? 2'b01 : (op == BT) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
    if (step == 0) begin
      irw = 1; pcw = 1; sa = 2'b00; sb = 2'b10; rs = 2'b10;
    end else if (step == 1) begin
      sa = 2'b01; sb = 2'b01;
    end else if (op == LW || op == SW) begin
      if (step == 2) begin sa = 2'b10; sb = 2'b01; end
      else if (op == LW && step == 3) adr = 1;
      else if (op == LW && step == 4) begin rs = 2'b01; regw = 1; ret = 1; end
      else if (op == SW && step == 3) begin adr = 1; memw = 1; ret = 1; end
    end else if (op == RT || op == IT) begin
      if (step == 2) begin
        sa = 2'b10; sb = (op == RT) ? 2'b00 : 2'b01;
        case (f3)
          3'b000:  alu = (op == RT && f7) ? SUB : ADD;
          3'b010:  alu = SLT;
          3'b100:  alu = XOR;
          3'b110:  alu = OR_;
          3'b111:  alu = AND_;
          default: alu = ADD;
        endcase
      end else if (step == 3) begin regw = 1; ret = 1; end
    end else if (op == BT) begin
      if (step == 2) begin sa = 2'b10; sb = 2'b00; alu = SUB; pcw = z; ret = 1; end
    end else if (op == JL) begin
      if (step == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      else if (step == 3) begin regw = 1; ret = 1; end
    end else begin
      ill = 1;
    end
    return {pcw, adr, memw, irw, regw, rs, sa, sb, imm, alu, ill, ret};
  endfunction

  function automatic int latency(input logic [6:0] op);
    if (op == LW) return 5;
    if (op == BT) return 3;
    return 4;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return (op == LW || op == SW || op == RT || op == IT || op == BT || op == JL);
  endfunction

  // Runs ncyc cycles of one instruction, starting in a FETCH cycle;
  // zmode 0/1 fixes i_zero, 2 randomizes it every cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode, input int ncyc);
    logic [18:0] exp, got;
    i_op = op; i_funct3 = f3; i_funct7b5 = f7;
    for (int s = 0; s < ncyc; s++) begin
      @(negedge clk);
      i_zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      exp = model(op, f3, f7, i_zero, s);
      got = {o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write, o_result_src,
             o_alu_src_a, o_alu_src_b, o_imm_src, o_alu_control, o_illegal, o_retire};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s step %0d op=%b f3=%b f7=%b z=%b got=%b exp=%b",
                 name, s, op, f3, f7, i_zero, got, exp);
      end
    end
  endtask

  task automatic check_enables_off(input string name);
    logic [5:0] en;
    en = {o_pc_write, o_mem_write, o_ir_write, o_reg_write, o_retire, o_illegal};
    checks++;
    if (en !== 6'b0) begin
      errors++;
      $display("FAIL %s enables got=%b exp=000000", name, en);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; i_op = SW; i_funct3 = 3'b000; i_funct7b5 = 1'b0; i_zero = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_enables_off("reset_hold");
    release_reset();
    run_instr("reset_first_fetch", RT, 3'b111, 1'b0, 2, 4);
  endtask

  task automatic test_lw();
    run_instr("lw", LW, 3'b010, 1'b0, 2, 5);
  endtask

  task automatic test_alu_decode();
    run_instr("r_sub", RT, 3'b000, 1'b1, 2, 4);
    run_instr("r_add", RT, 3'b000, 1'b0, 2, 4);
    run_instr("i_add_f7", IT, 3'b000, 1'b1, 2, 4);
    run_instr("r_xor", RT, 3'b100, 1'b0, 2, 4);
    run_instr("i_slt", IT, 3'b010, 1'b1, 2, 4);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", BT, 3'b000, 1'b0, 1, 3);
    run_instr("beq_not_taken", BT, 3'b000, 1'b0, 0, 3);
  endtask

  task automatic test_jal();
    run_instr("jal", JL, 3'b101, 1'b1, 2, 4);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    logic [6:0] op;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BT; ops[5] = JL;
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      run_instr("random", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2,
                latency(op));
    end
  endtask

  task automatic test_reset_mid_memwrite();
    run_instr("sw_pre", SW, 3'b010, 1'b0, 2, 3);
    @(negedge clk); #1;
    checks++;
    if (o_mem_write !== 1'b1) begin
      errors++;
      $display("FAIL memwrite_before_reset got=%b exp=1", o_mem_write);
    end
    arst = 1'b1; #1;
    check_enables_off("reset_async_drop");
    @(posedge clk); #1;
    check_enables_off("reset_held_edge");
    release_reset();
    run_instr("after_reset_lw", LW, 3'b010, 1'b0, 2, 5);
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    run_instr("illegal_zero", 7'b0000000, 3'b000, 1'b0, 2, 14);
    arst = 1'b1; #1;
    check_enables_off("illegal_reset");
    release_reset();
    op = 7'($urandom_range(0, 127));
    while (is_legal(op)) op = 7'($urandom_range(0, 127));
    run_instr("illegal_random", op, 3'($urandom_range(0, 7)), 1'b1, 2, 12);
    arst = 1'b1; #1;
    check_enables_off("illegal_reset2");
    release_reset();
    run_instr("post_illegal_beq", BT, 3'b000, 1'b0, 2, 3);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu_decode();
    test_beq();
    test_jal();
    test_back_to_back();
    test_reset_mid_memwrite();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
